rx_char_sequencer: RTL and testbench

- Control stage behind the receive character decode/parity registers.
- Takes each registered control or data character with its received and generated parity bits.
- Classifies it as NULL, FCT, EOP, EEP, ESC, time-code or data, and checks parity, escape sequences and receive credit.
- Drives the receive FIFO write port, time-code outputs and the gotX/error indications to the link state machine.

---
 rtl/spw_rx_pkg.sv | 30 +++
 rtl/rx_char_sequencer_if.sv | 30 +++
 rtl/rx_char_sequencer_credit.sv | 41 ++++
 rtl/rx_char_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_rx_char_sequencer.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spw_rx_pkg.sv
// Shared definitions for the receive character sequencer: control codes,
// FIFO end-of-packet markers and the sequencer state encoding.
package spw_rx_pkg;

  localparam int unsigned CODE_W   = 2;
  localparam int unsigned FIFO_W   = 9;
  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned CREDIT_W = 6;

  localparam logic [CODE_W-1:0] CODE_FCT = 2'b00;
  localparam logic [CODE_W-1:0] CODE_EOP = 2'b01;
  localparam logic [CODE_W-1:0] CODE_EEP = 2'b10;
  localparam logic [CODE_W-1:0] CODE_ESC = 2'b11;

  localparam logic [FIFO_W-1:0] MARK_EOP = 9'h100;
  localparam logic [FIFO_W-1:0] MARK_EEP = 9'h101;

  typedef enum logic [1:0] {
    ST_DISABLED  = 2'd0,
    ST_WAIT_NULL = 2'd1,
    ST_RUN       = 2'd2,
    ST_ERROR     = 2'd3
  } rx_state_e;

  // FIFO word for an end-of-packet control character
  function automatic logic [FIFO_W-1:0] eop_word(input logic [CODE_W-1:0] code);
    return (code == CODE_EOP) ? MARK_EOP : MARK_EEP;
  endfunction

endpackage

// File: rtl/rx_char_sequencer_if.sv
// Character input bus from the decode/parity registers plus the receive FIFO write port.
interface rx_char_sequencer_if;

  logic                             char_valid_c;
  logic                             char_valid_d;
  logic [2:0]                       control_p_r;
  logic [spw_rx_pkg::FIFO_W-1:0]    dta_timec_p;
  logic                             parity_rec_c;
  logic                             parity_rec_c_gen;
  logic                             parity_rec_d;
  logic                             parity_rec_d_gen;
  logic                             rx_fifo_full;
  logic                             rx_fifo_wr;
  logic [spw_rx_pkg::FIFO_W-1:0]    rx_fifo_data;

  modport master (
    output char_valid_c, char_valid_d, control_p_r, dta_timec_p,
           parity_rec_c, parity_rec_c_gen, parity_rec_d, parity_rec_d_gen,
           rx_fifo_full,
    input  rx_fifo_wr, rx_fifo_data
  );

  modport slave (
    input  char_valid_c, char_valid_d, control_p_r, dta_timec_p,
           parity_rec_c, parity_rec_c_gen, parity_rec_d, parity_rec_d_gen,
           rx_fifo_full,
    output rx_fifo_wr, rx_fifo_data
  );

endinterface

// File: rtl/rx_char_sequencer_credit.sv
// Receive credit counter: saturating add of one FCT step, single decrement per
// accepted N-char, and a flag telling whether an N-char this cycle would underflow.
module rx_credit_counter
  import spw_rx_pkg::*;
#(
  parameter int unsigned MAX_CREDIT  = 56,
  parameter int unsigned CREDIT_STEP = 8
) (
  input  logic                posedge_clk,
  input  logic                rx_reset,
  input  logic                clr,
  input  logic                inc,
  input  logic                dec,
  output logic [CREDIT_W-1:0] credit,
  output logic                underflow_c
);

  localparam int unsigned SUM_W = CREDIT_W + 1;

  logic [SUM_W-1:0] sum;

  // Coincident FCT and N-char net to +step-1 before saturation
  always_comb begin
    sum = SUM_W'(credit);
    if (inc) sum = sum + SUM_W'(CREDIT_STEP);
    if (dec) sum = sum - SUM_W'(1);
  end

  assign underflow_c = (credit == '0) && !inc;

  always_ff @(posedge posedge_clk) begin
    if (rx_reset || clr) begin
      credit <= '0;
    end else if (sum > SUM_W'(MAX_CREDIT)) begin
      credit <= CREDIT_W'(MAX_CREDIT);
    end else begin
      credit <= CREDIT_W'(sum);
    end
  end

endmodule

// File: rtl/rx_char_sequencer.sv
// Receive control stage: classifies each registered character, checks parity,
// escape sequences and credit, and drives the FIFO, time-code and link indications.
module rx_char_sequencer
  import spw_rx_pkg::*;
#(
  parameter int unsigned MAX_CREDIT  = 56,
  parameter int unsigned CREDIT_STEP = 8
) (
  input  logic                posedge_clk,
  input  logic                rx_reset,
  input  logic                rx_enable,
  input  logic                fct_sent,
  rx_char_sequencer_if.slave  bus,
  output logic                tick_out,
  output logic [BYTE_W-1:0]   time_out,
  output logic                got_null,
  output logic                got_fct,
  output logic                got_nchar,
  output logic                got_time,
  output logic                parity_error,
  output logic                esc_error,
  output logic                credit_error,
  output logic [CREDIT_W-1:0] rx_credit
);

  rx_state_e state_q, state_d;
  logic esc_q, esc_d;

  logic              wr_d, tick_d, null_d, fct_d, nchar_d, time_d;
  logic              par_err_d, esc_err_d, cred_err_d;
  logic [FIFO_W-1:0] data_d;
  logic [BYTE_W-1:0] time_val_d;

  logic              char_v, is_ctrl, par_bad, is_fct, is_esc;
  logic [CODE_W-1:0] code;
  logic [FIFO_W-1:0] nchar_word;
  logic              credit_clr, credit_inc, credit_dec, underflow_c;
  logic              unused_bits;

  // Control char wins when both valids arrive together
  assign char_v     = bus.char_valid_c || bus.char_valid_d;
  assign is_ctrl    = bus.char_valid_c;
  assign code       = bus.control_p_r[CODE_W-1:0];
  assign is_fct     = is_ctrl && (code == CODE_FCT);
  assign is_esc     = is_ctrl && (code == CODE_ESC);
  assign par_bad    = is_ctrl ? (bus.parity_rec_c != bus.parity_rec_c_gen)
                              : (bus.parity_rec_d != bus.parity_rec_d_gen);
  assign nchar_word = is_ctrl ? eop_word(code) : {1'b0, bus.dta_timec_p[BYTE_W-1:0]};
  assign unused_bits = ^{bus.control_p_r[2], bus.dta_timec_p[FIFO_W-1]};

  assign credit_clr = !rx_enable || (state_q == ST_DISABLED);
  assign credit_inc = fct_sent && rx_enable &&
                      ((state_q == ST_WAIT_NULL) || (state_q == ST_RUN));

  rx_credit_counter #(
    .MAX_CREDIT  (MAX_CREDIT),
    .CREDIT_STEP (CREDIT_STEP)
  ) u_credit (
    .posedge_clk (posedge_clk),
    .rx_reset    (rx_reset),
    .clr         (credit_clr),
    .inc         (credit_inc),
    .dec         (credit_dec),
    .credit      (rx_credit),
    .underflow_c (underflow_c)
  );

  always_ff @(posedge posedge_clk) begin
    if (rx_reset) begin
      state_q <= ST_DISABLED;
      esc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      esc_q   <= esc_d;
    end
  end

  // Next state and next values of every registered output
  always_comb begin
    state_d    = state_q;
    esc_d      = esc_q;
    wr_d       = 1'b0;
    data_d     = bus.rx_fifo_data;
    tick_d     = 1'b0;
    time_d     = 1'b0;
    time_val_d = time_out;
    null_d     = 1'b0;
    fct_d      = 1'b0;
    nchar_d    = 1'b0;
    par_err_d  = parity_error;
    esc_err_d  = esc_error;
    cred_err_d = credit_error;
    credit_dec = 1'b0;

    if (!rx_enable) begin
      state_d    = ST_DISABLED;
      esc_d      = 1'b0;
      par_err_d  = 1'b0;
      esc_err_d  = 1'b0;
      cred_err_d = 1'b0;
    end else begin
      case (state_q)
        ST_DISABLED: begin
          state_d = ST_WAIT_NULL;
          esc_d   = 1'b0;
        end
        ST_WAIT_NULL: begin
          if (char_v) begin
            esc_d = is_esc;
            if (is_fct && esc_q) begin
              null_d  = 1'b1;
              state_d = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (char_v) begin
            esc_d = 1'b0;
            if (par_bad) begin
              par_err_d = 1'b1;
              state_d   = ST_ERROR;
            end else if (esc_q) begin
              if (is_fct) begin
                null_d = 1'b1;
              end else if (!is_ctrl) begin
                tick_d     = 1'b1;
                time_d     = 1'b1;
                time_val_d = bus.dta_timec_p[BYTE_W-1:0];
              end else begin
                esc_err_d = 1'b1;
                state_d   = ST_ERROR;
              end
            end else if (is_esc) begin
              esc_d = 1'b1;
            end else if (is_fct) begin
              fct_d = 1'b1;
            end else if (bus.rx_fifo_full || underflow_c) begin
              cred_err_d = 1'b1;
              state_d    = ST_ERROR;
            end else begin
              wr_d       = 1'b1;
              data_d     = nchar_word;
              nchar_d    = 1'b1;
              credit_dec = 1'b1;
            end
          end
        end
        ST_ERROR: begin
          state_d = ST_ERROR;
        end
        default: begin
          state_d = ST_DISABLED;
        end
      endcase
    end
  end

  always_ff @(posedge posedge_clk) begin
    if (rx_reset) begin
      bus.rx_fifo_wr   <= 1'b0;
      bus.rx_fifo_data <= '0;
      tick_out         <= 1'b0;
      time_out         <= '0;
      got_null         <= 1'b0;
      got_fct          <= 1'b0;
      got_nchar        <= 1'b0;
      got_time         <= 1'b0;
      parity_error     <= 1'b0;
      esc_error        <= 1'b0;
      credit_error     <= 1'b0;
    end else begin
      bus.rx_fifo_wr   <= wr_d;
      bus.rx_fifo_data <= data_d;
      tick_out         <= tick_d;
      time_out         <= time_val_d;
      got_null         <= null_d;
      got_fct          <= fct_d;
      got_nchar        <= nchar_d;
      got_time         <= time_d;
      parity_error     <= par_err_d;
      esc_error        <= esc_err_d;
      credit_error     <= cred_err_d;
    end
  end

endmodule

// File: tb/tb_rx_char_sequencer.sv
// Self-checking bench for rx_char_sequencer: directed link scenarios followed by
// randomized character traffic, checked cycle by cycle against a behavioural model.
module tb_rx_char_sequencer;

  localparam int MAXC = 56;
  localparam int STEP = 8;

  localparam int K_NONE = 0;
  localparam int K_DATA = 1;
  localparam int K_FCT  = 2;
  localparam int K_EOP  = 3;
  localparam int K_EEP  = 4;
  localparam int K_ESC  = 5;

  logic       posedge_clk = 1'b0;
  logic       rx_reset;
  logic       rx_enable;
  logic       fct_sent;
  logic       tick_out;
  logic [7:0] time_out;
  logic       got_null, got_fct, got_nchar, got_time;
  logic       parity_error, esc_error, credit_error;
  logic [5:0] rx_credit;

  rx_char_sequencer_if bus ();

  rx_char_sequencer #(.MAX_CREDIT(MAXC), .CREDIT_STEP(STEP)) dut (
    .posedge_clk  (posedge_clk),
    .rx_reset     (rx_reset),
    .rx_enable    (rx_enable),
    .fct_sent     (fct_sent),
    .bus          (bus),
    .tick_out     (tick_out),
    .time_out     (time_out),
    .got_null     (got_null),
    .got_fct      (got_fct),
    .got_nchar    (got_nchar),
    .got_time     (got_time),
    .parity_error (parity_error),
    .esc_error    (esc_error),
    .credit_error (credit_error),
    .rx_credit    (rx_credit)
  );

  always #5 posedge_clk = ~posedge_clk;

  int n_err = 0;
  int n_chk = 0;

  // Behavioural view of the link: enabled, linked (NULL seen), failed
  bit m_up, m_linked, m_dead, m_esc;
  bit m_perr, m_eerr, m_cerr;
  int m_credit;
  int m_time;
  bit e_wr, e_null, e_fct, e_nchar, e_tick;
  int e_data;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input int kind, input logic [7:0] b, input bit badp,
                       input bit fct, input bit full);
    bit accept;
    bit was_esc;
    e_wr = 0; e_null = 0; e_fct = 0; e_nchar = 0; e_tick = 0;
    accept = 0;
    if (!rx_enable) begin
      m_up = 0; m_linked = 0; m_dead = 0; m_esc = 0; m_credit = 0;
      m_perr = 0; m_eerr = 0; m_cerr = 0;
      return;
    end
    if (!m_up) begin
      m_up = 1;
      return;
    end
    if (m_dead) return;
    if (!m_linked) begin
      if (kind != K_NONE) begin
        if (kind == K_FCT && m_esc) begin
          e_null = 1;
          m_linked = 1;
        end
        m_esc = (kind == K_ESC);
      end
      if (fct) m_credit = (m_credit + STEP > MAXC) ? MAXC : m_credit + STEP;
      return;
    end
    if (kind != K_NONE) begin
      was_esc = m_esc;
      m_esc = 0;
      if (badp) begin
        m_perr = 1; m_dead = 1;
      end else if (was_esc) begin
        if (kind == K_FCT) e_null = 1;
        else if (kind == K_DATA) begin e_tick = 1; m_time = int'(b); end
        else begin m_eerr = 1; m_dead = 1; end
      end else if (kind == K_ESC) begin
        m_esc = 1;
      end else if (kind == K_FCT) begin
        e_fct = 1;
      end else if (full || (m_credit == 0 && !fct)) begin
        m_cerr = 1; m_dead = 1;
      end else begin
        accept = 1; e_wr = 1; e_nchar = 1;
        e_data = (kind == K_DATA) ? int'(b) : (kind == K_EOP) ? 'h100 : 'h101;
      end
    end
    m_credit = m_credit + (fct ? STEP : 0) - (accept ? 1 : 0);
    if (m_credit > MAXC) m_credit = MAXC;
  endtask

  task automatic cyc(input int kind, input logic [7:0] b, input bit badp,
                     input bit fct, input bit full);
    logic [1:0] code;
    logic       pc, pd;
    code = (kind == K_FCT) ? 2'b00 : (kind == K_EOP) ? 2'b01 :
           (kind == K_EEP) ? 2'b10 : 2'b11;
    pc = 1'($urandom_range(0, 1));
    pd = 1'($urandom_range(0, 1));
    bus.char_valid_c     = (kind != K_NONE) && (kind != K_DATA);
    bus.char_valid_d     = (kind == K_DATA);
    bus.control_p_r      = {1'($urandom_range(0, 1)), code};
    bus.dta_timec_p      = {1'b0, b};
    bus.parity_rec_c     = pc;
    bus.parity_rec_c_gen = (bus.char_valid_c && badp) ? ~pc : pc;
    bus.parity_rec_d     = pd;
    bus.parity_rec_d_gen = (bus.char_valid_d && badp) ? ~pd : pd;
    fct_sent             = fct;
    bus.rx_fifo_full     = full;
    model(kind, b, badp, fct, full);
    @(posedge posedge_clk);
    #1;
    chk("fifo_wr", 16'(bus.rx_fifo_wr), 16'(e_wr));
    if (e_wr) chk("fifo_data", 16'(bus.rx_fifo_data), 16'(e_data));
    chk("got_null", 16'(got_null), 16'(e_null));
    chk("got_fct", 16'(got_fct), 16'(e_fct));
    chk("got_nchar", 16'(got_nchar), 16'(e_nchar));
    chk("tick_out", 16'(tick_out), 16'(e_tick));
    chk("got_time", 16'(got_time), 16'(e_tick));
    chk("time_out", 16'(time_out), 16'(m_time));
    chk("parity_error", 16'(parity_error), 16'(m_perr));
    chk("esc_error", 16'(esc_error), 16'(m_eerr));
    chk("credit_error", 16'(credit_error), 16'(m_cerr));
    chk("rx_credit", 16'(rx_credit), 16'(m_credit));
    bus.char_valid_c = 1'b0;
    bus.char_valid_d = 1'b0;
    fct_sent         = 1'b0;
    bus.rx_fifo_full = 1'b0;
  endtask

  task automatic relink();
    rx_enable = 1'b0;
    cyc(K_NONE, 8'h00, 0, 0, 0);
    rx_enable = 1'b1;
    cyc(K_NONE, 8'h00, 0, 0, 0);
    cyc(K_ESC, 8'h00, 0, 0, 0);
    cyc(K_FCT, 8'h00, 0, 0, 0);
  endtask

  initial begin
    rx_reset = 1'b1; rx_enable = 1'b0; fct_sent = 1'b0;
    bus.char_valid_c = 1'b0; bus.char_valid_d = 1'b0;
    bus.control_p_r = '0; bus.dta_timec_p = '0;
    bus.parity_rec_c = 1'b0; bus.parity_rec_c_gen = 1'b0;
    bus.parity_rec_d = 1'b0; bus.parity_rec_d_gen = 1'b0;
    bus.rx_fifo_full = 1'b0;
    m_up = 0; m_linked = 0; m_dead = 0; m_esc = 0;
    m_perr = 0; m_eerr = 0; m_cerr = 0; m_credit = 0; m_time = 0;
    e_data = 0;

    repeat (2) @(posedge posedge_clk);
    #1;
    chk("rst_fifo_wr", 16'(bus.rx_fifo_wr), 16'h0);
    chk("rst_fifo_data", 16'(bus.rx_fifo_data), 16'h0);
    chk("rst_time_out", 16'(time_out), 16'h0);
    chk("rst_credit", 16'(rx_credit), 16'h0);
    chk("rst_errors", 16'({parity_error, esc_error, credit_error}), 16'h0);
    rx_reset = 1'b0;

    // Data before NULL is ignored; ESC,FCT links up
    rx_enable = 1'b1;
    cyc(K_NONE, 8'h00, 0, 0, 0);
    cyc(K_DATA, 8'hA5, 0, 0, 0);
    cyc(K_ESC, 8'h00, 0, 0, 0);
    cyc(K_FCT, 8'h00, 0, 0, 0);
    chk("link_null", 16'(got_null), 16'h1);

    // One credit step admits eight chars; the EOP that follows has no credit
    cyc(K_NONE, 8'h00, 0, 1, 0);
    for (int i = 0; i < 8; i++) cyc(K_DATA, 8'(i), 0, 0, 0);
    cyc(K_EOP, 8'h00, 0, 0, 0);
    chk("eop_no_credit_err", 16'(credit_error), 16'h1);
    chk("eop_no_credit_wr", 16'(bus.rx_fifo_wr), 16'h0);

    // Time-code, then an escape error, then disable clears errors
    relink();
    cyc(K_NONE, 8'h00, 0, 1, 0);
    cyc(K_ESC, 8'h00, 0, 0, 0);
    cyc(K_DATA, 8'h3F, 0, 0, 0);
    chk("tc_time_out", 16'(time_out), 16'h3F);
    chk("tc_credit", 16'(rx_credit), 16'd8);
    cyc(K_ESC, 8'h00, 0, 0, 0);
    cyc(K_EOP, 8'h00, 0, 0, 0);
    chk("esc_eop_err", 16'(esc_error), 16'h1);
    cyc(K_DATA, 8'h11, 0, 0, 0);
    rx_enable = 1'b0;
    cyc(K_NONE, 8'h00, 0, 0, 0);
    chk("disable_clears", 16'({parity_error, esc_error, credit_error}), 16'h0);

    // Parity error on a data char
    relink();
    cyc(K_NONE, 8'h00, 0, 1, 0);
    cyc(K_DATA, 8'h12, 1, 0, 0);
    chk("parity_err", 16'(parity_error), 16'h1);

    // Coincident FCT and N-char at zero credit, then saturation
    relink();
    cyc(K_DATA, 8'h55, 0, 1, 0);
    chk("coinc_data", 16'(bus.rx_fifo_data), 16'h055);
    chk("coinc_credit", 16'(rx_credit), 16'd7);
    repeat (7) cyc(K_NONE, 8'h00, 0, 1, 0);
    chk("credit_sat", 16'(rx_credit), 16'd56);
    cyc(K_EEP, 8'h00, 0, 1, 0);
    cyc(K_DATA, 8'h77, 0, 0, 1);

    // Disable in the middle of an escape discards the pending ESC
    relink();
    cyc(K_ESC, 8'h00, 0, 0, 0);
    rx_enable = 1'b0;
    cyc(K_NONE, 8'h00, 0, 0, 0);
    rx_enable = 1'b1;
    cyc(K_NONE, 8'h00, 0, 0, 0);
    cyc(K_FCT, 8'h00, 0, 0, 0);
    chk("esc_discarded", 16'(got_null), 16'h0);

    // Random traffic sessions
    for (int s = 0; s < 6; s++) begin
      relink();
      for (int n = 0; n < 80; n++) begin
        int  r;
        int  kind;
        bit  f, full, bad;
        r    = int'($urandom_range(0, 9));
        kind = (r <= 1) ? K_NONE : (r <= 4) ? K_DATA : (r == 5) ? K_EOP :
               (r == 6) ? K_EEP : (r == 7) ? K_FCT : (r == 8) ? K_ESC : K_NONE;
        f    = ($urandom_range(0, 3) == 0);
        full = ($urandom_range(0, 24) == 0);
        bad  = ($urandom_range(0, 60) == 0);
        cyc(kind, 8'($urandom_range(0, 255)), bad, f, full);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
